weight_update_unit: RTL and testbench

WEIGHT_UPDATE_UNIT -- requirements
Module: weight_update_unit

---
 rtl/weight_update_unit.sv | 175 +++++++++++++++++
 tb/tb_weight_update_unit.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_update_unit.sv
// weight_update_unit: per-layer weight register file updated by a pipelined FP subtract (w - error).
// Optional macro WEIGHT_CLIP_EN saturates updated weights to +/-WEIGHT_CLIP.

module weight_update_fp_add (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        valid_in,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    output logic        valid_out,
    output logic [31:0] result
);
    logic        v_q;
    logic [31:0] a_q, b_q, x, y, sum_c;
    logic        swap, sticky, round_up;
    logic [7:0]  d8;
    logic [26:0] mx, my, shifted, aligned, norm;
    logic [27:0] raw;
    logic [9:0]  exp_n;
    logic [24:0] m_rnd;
    logic [22:0] mant;
    int          msb;

    // Denormals flush to zero; rounding is round-to-nearest-even with guard/round/sticky bits.
    always_comb begin
        swap    = a_q[30:0] < b_q[30:0];
        x       = swap ? b_q : a_q;
        y       = swap ? a_q : b_q;
        mx      = (x[30:23] == 8'd0) ? 27'd0 : {1'b1, x[22:0], 3'b000};
        my      = (y[30:23] == 8'd0) ? 27'd0 : {1'b1, y[22:0], 3'b000};
        d8      = x[30:23] - y[30:23];
        shifted = 27'd0;
        sticky  = 1'b0;
        if (d8 > 8'd26) begin
            sticky = |my;
        end else begin
            shifted = my >> d8;
            sticky  = ((shifted << d8) != my);
        end
        aligned = {shifted[26:1], shifted[0] | sticky};
        raw = (x[31] == y[31]) ? ({1'b0, mx} + {1'b0, aligned})
                               : ({1'b0, mx} - {1'b0, aligned});
        msb = 0;
        for (int i = 0; i < 28; i++) begin
            if (raw[i]) msb = i;
        end
        exp_n = {2'b00, x[30:23]};
        if (raw[27]) begin
            norm  = {raw[27:2], raw[1] | raw[0]};
            exp_n = exp_n + 10'd1;
        end else begin
            norm  = raw[26:0] << (26 - msb);
            exp_n = exp_n - 10'(26 - msb);
        end
        round_up = norm[2] & (norm[1] | norm[0] | norm[3]);
        m_rnd    = {1'b0, norm[26:3]} + {24'd0, round_up};
        mant     = m_rnd[24] ? m_rnd[23:1] : m_rnd[22:0];
        if (m_rnd[24]) exp_n = exp_n + 10'd1;
        if (raw == 28'd0 || exp_n[9] || exp_n == 10'd0)
            sum_c = 32'd0;
        else if (exp_n >= 10'd255)
            sum_c = {x[31], 8'hFF, 23'd0};
        else
            sum_c = {x[31], exp_n[7:0], mant};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q       <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            valid_out <= 1'b0;
            result    <= '0;
        end else begin
            v_q       <= valid_in;
            a_q       <= in_a;
            b_q       <= in_b;
            valid_out <= v_q;
            result    <= sum_c;
        end
    end
endmodule

module weight_update_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_WEIGHT = 32,
    parameter int ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] WEIGHT_CLIP = 'h40000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_error,
    input  logic                  i_load_valid,
    input  logic [ADDR_WIDTH-1:0] i_load_addr,
    input  logic [DATA_WIDTH-1:0] i_load_data,
    input  logic [ADDR_WIDTH-1:0] i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_valid,
    output logic                  o_done,
    output logic                  o_busy
);
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_WEIGHT - 1);
    localparam logic [ADDR_WIDTH:0]   NUM_W    = (ADDR_WIDTH + 1)'(NUM_WEIGHT);
`ifdef WEIGHT_CLIP_EN
    localparam bit CLIP_EN = 1'b1;
`else
    localparam bit CLIP_EN = 1'b0;
`endif

    logic [DATA_WIDTH-1:0] w [NUM_WEIGHT];
    logic [ADDR_WIDTH-1:0] seq_cnt, wb_idx;
    logic [ADDR_WIDTH-1:0] idx_fifo [16];
    logic [3:0]            wr_ptr, rd_ptr;
    logic [4:0]            fifo_cnt;
    logic                  add_valid, load_ok, over_clip;
    logic [DATA_WIDTH-1:0] add_sum, wb_data;

    assign o_busy    = (seq_cnt != '0) || (fifo_cnt != '0);
    assign load_ok   = i_load_valid && !o_busy && ({1'b0, i_load_addr} < NUM_W);
    assign wb_idx    = idx_fifo[rd_ptr];
    assign over_clip = add_sum[30:0] > WEIGHT_CLIP[30:0];
    assign wb_data   = (CLIP_EN && over_clip) ? {add_sum[31], WEIGHT_CLIP[30:0]} : add_sum;

    // Subtraction is done by flipping the sign of the error before the adder.
    weight_update_fp_add u_add (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (i_valid),
        .in_a     (w[seq_cnt]),
        .in_b     ({~i_error[DATA_WIDTH-1], i_error[DATA_WIDTH-2:0]}),
        .valid_out(add_valid),
        .result   (add_sum)
    );

    // Index FIFO carries each error's weight index past the adder latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_cnt  <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
            for (int i = 0; i < 16; i++) idx_fifo[i] <= '0;
        end else begin
            if (i_valid) begin
                idx_fifo[wr_ptr] <= seq_cnt;
                wr_ptr           <= wr_ptr + 4'd1;
                seq_cnt          <= (seq_cnt == LAST_IDX) ? '0 : seq_cnt + ADDR_WIDTH'(1);
            end
            if (add_valid) rd_ptr <= rd_ptr + 4'd1;
            if (i_valid && !add_valid)
                fifo_cnt <= fifo_cnt + 5'd1;
            else if (!i_valid && add_valid)
                fifo_cnt <= fifo_cnt - 5'd1;
        end
    end

    // Write-back outranks loads; loads only land while idle, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WEIGHT; i++) w[i] <= '0;
            o_rd_data <= '0;
            o_valid   <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            if (add_valid)
                w[wb_idx] <= wb_data;
            else if (load_ok)
                w[i_load_addr] <= i_load_data;
            o_valid   <= add_valid;
            o_done    <= add_valid && (wb_idx == LAST_IDX);
            o_rd_data <= ({1'b0, i_rd_addr} < NUM_W) ? w[i_rd_addr] : '0;
        end
    end
endmodule

// File: tb/tb_weight_update_unit.sv
// Directed self-checking bench for weight_update_unit (honours WEIGHT_CLIP_EN for clip expectations).

module tb_weight_update_unit;
    logic        clk;
    logic        rst_n;
    logic        i_valid;
    logic [31:0] i_error;
    logic        i_load_valid;
    logic [4:0]  i_load_addr;
    logic [31:0] i_load_data;
    logic [4:0]  i_rd_addr;
    logic [31:0] o_rd_data;
    logic        o_valid;
    logic        o_done;
    logic        o_busy;

    int checks = 0;
    int failures = 0;
    int valid_cnt = 0;
    int done_cnt = 0;
    int done_at = 0;

`ifdef WEIGHT_CLIP_EN
    localparam logic [31:0] EXP_W3 = 32'h40000000;
    localparam logic [31:0] EXP_W4 = 32'hC0000000;
`else
    localparam logic [31:0] EXP_W3 = 32'h40200000;
    localparam logic [31:0] EXP_W4 = 32'hC0200000;
`endif

    weight_update_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_valid     (i_valid),
        .i_error     (i_error),
        .i_load_valid(i_load_valid),
        .i_load_addr (i_load_addr),
        .i_load_data (i_load_data),
        .i_rd_addr   (i_rd_addr),
        .o_rd_data   (o_rd_data),
        .o_valid     (o_valid),
        .o_done      (o_done),
        .o_busy      (o_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (o_valid) valid_cnt++;
        if (o_done) begin
            done_cnt++;
            done_at = valid_cnt;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic apply_reset;
        @(negedge clk);
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_error = '0;
        i_load_valid = 1'b0;
        i_load_addr = '0;
        i_load_data = '0;
        i_rd_addr = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_weight(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        i_load_valid = 1'b1;
        i_load_addr = addr;
        i_load_data = data;
        @(negedge clk);
        i_load_valid = 1'b0;
    endtask

    task automatic read_weight(input logic [4:0] addr, output logic [31:0] data);
        @(negedge clk);
        i_rd_addr = addr;
        @(negedge clk);
        data = o_rd_data;
    endtask

    task automatic send_error(input logic [31:0] err);
        @(negedge clk);
        i_valid = 1'b1;
        i_error = err;
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!o_busy) begin
                ok = 1'b1;
                break;
            end
        end
        #1;
    endtask

    task automatic test_reset;
        logic [31:0] rd;
        rst_n = 1'b0;
        i_valid = 1'b0;
        i_error = '0;
        i_load_valid = 1'b0;
        i_load_addr = '0;
        i_load_data = '0;
        i_rd_addr = 5'd5;
        repeat (2) @(negedge clk);
        checks++;
        if (o_rd_data !== 32'd0) begin failures++; $display("[TB] FAIL reset_rd_data: got %h expected 00000000", o_rd_data); end
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", o_done); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", o_busy); end
        rst_n = 1'b1;
        read_weight(5'd5, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL reset_w5: got %h expected 00000000", rd); end
    endtask

    task automatic test_single_update;
        logic [31:0] rd;
        int base_v, base_d;
        apply_reset();
        load_weight(5'd0, 32'h3F800000);
        #1;
        base_v = valid_cnt;
        base_d = done_cnt;
        send_error(32'h3E800000);
        @(negedge clk);
        i_valid = 1'b0;
        #1;
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL single_busy: got %b expected 1", o_busy); end
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt - base_v !== 1) begin failures++; $display("[TB] FAIL single_valid_count: got %0d expected 1", valid_cnt - base_v); end
        checks++;
        if (done_cnt - base_d !== 0) begin failures++; $display("[TB] FAIL single_done_count: got %0d expected 0", done_cnt - base_d); end
        read_weight(5'd0, rd);
        checks++;
        if (rd !== 32'h3F400000) begin failures++; $display("[TB] FAIL single_w0: got %h expected 3F400000", rd); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] rd;
        int base_v, base_d;
        bit ok;
        apply_reset();
        #1;
        base_v = valid_cnt;
        base_d = done_cnt;
        for (int i = 0; i < 32; i++) send_error(32'hBF800000);
        @(negedge clk);
        i_valid = 1'b0;
        wait_idle(100, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL b2b_idle_timeout: got busy=%b expected 0 within 100 cycles", o_busy); end
        checks++;
        if (valid_cnt - base_v !== 32) begin failures++; $display("[TB] FAIL b2b_valid_count: got %0d expected 32", valid_cnt - base_v); end
        checks++;
        if (done_cnt - base_d !== 1) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 1", done_cnt - base_d); end
        checks++;
        if (done_at - base_v !== 32) begin failures++; $display("[TB] FAIL b2b_done_position: got %0d expected 32", done_at - base_v); end
        for (int i = 0; i < 32; i++) begin
            read_weight(5'(i), rd);
            checks++;
            if (rd !== 32'h3F800000) begin failures++; $display("[TB] FAIL b2b_w%0d: got %h expected 3F800000", i, rd); end
        end
    endtask

    task automatic test_clip;
        logic [31:0] rd;
        apply_reset();
        load_weight(5'd3, 32'h3FC00000);
        load_weight(5'd4, 32'hBFC00000);
        for (int i = 0; i < 3; i++) send_error(32'h00000000);
        send_error(32'hBF800000);
        send_error(32'h3F800000);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        read_weight(5'd0, rd);
        checks++;
        if (rd !== 32'h00000000) begin failures++; $display("[TB] FAIL clip_w0: got %h expected 00000000", rd); end
        read_weight(5'd3, rd);
        checks++;
        if (rd !== EXP_W3) begin failures++; $display("[TB] FAIL clip_w3: got %h expected %h", rd, EXP_W3); end
        read_weight(5'd4, rd);
        checks++;
        if (rd !== EXP_W4) begin failures++; $display("[TB] FAIL clip_w4: got %h expected %h", rd, EXP_W4); end
    endtask

    task automatic test_load_while_busy;
        logic [31:0] rd;
        apply_reset();
        load_weight(5'd2, 32'h3F800000);
        send_error(32'h3E800000);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("[TB] FAIL busy_load_busy: got %b expected 1", o_busy); end
        load_weight(5'd2, 32'h40400000);
        load_weight(5'd0, 32'h40400000);
        read_weight(5'd2, rd);
        checks++;
        if (rd !== 32'h3F800000) begin failures++; $display("[TB] FAIL busy_load_w2: got %h expected 3F800000", rd); end
        read_weight(5'd0, rd);
        checks++;
        if (rd !== 32'hBE800000) begin failures++; $display("[TB] FAIL busy_load_w0: got %h expected BE800000", rd); end
    endtask

    task automatic test_mid_reset;
        logic [31:0] rd;
        int base_v;
        apply_reset();
        for (int i = 0; i < 10; i++) send_error(32'hBF800000);
        @(negedge clk);
        i_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        base_v = valid_cnt;
        checks++;
        if (o_valid !== 1'b0) begin failures++; $display("[TB] FAIL midrst_valid: got %b expected 0", o_valid); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy: got %b expected 0", o_busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt !== base_v) begin failures++; $display("[TB] FAIL midrst_no_valid: got %0d pulses expected 0", valid_cnt - base_v); end
        for (int i = 0; i < 10; i++) begin
            read_weight(5'(i), rd);
            checks++;
            if (rd !== 32'd0) begin failures++; $display("[TB] FAIL midrst_w%0d: got %h expected 00000000", i, rd); end
        end
        #1;
        base_v = valid_cnt;
        send_error(32'hBF800000);
        @(negedge clk);
        i_valid = 1'b0;
        repeat (6) @(negedge clk);
        #1;
        checks++;
        if (valid_cnt - base_v !== 1) begin failures++; $display("[TB] FAIL midrst_next_valid: got %0d expected 1", valid_cnt - base_v); end
        read_weight(5'd0, rd);
        checks++;
        if (rd !== 32'h3F800000) begin failures++; $display("[TB] FAIL midrst_next_w0: got %h expected 3F800000", rd); end
        read_weight(5'd1, rd);
        checks++;
        if (rd !== 32'd0) begin failures++; $display("[TB] FAIL midrst_next_w1: got %h expected 00000000", rd); end
    endtask

    task automatic test_two_passes;
        logic [31:0] rd;
        int base_v, base_d;
        bit ok;
        apply_reset();
        #1;
        base_v = valid_cnt;
        base_d = done_cnt;
        for (int i = 0; i < 64; i++) send_error((i < 32) ? 32'hBF800000 : 32'h3E800000);
        @(negedge clk);
        i_valid = 1'b0;
        wait_idle(150, ok);
        checks++;
        if (!ok) begin failures++; $display("[TB] FAIL two_pass_idle_timeout: got busy=%b expected 0 within 150 cycles", o_busy); end
        checks++;
        if (valid_cnt - base_v !== 64) begin failures++; $display("[TB] FAIL two_pass_valid_count: got %0d expected 64", valid_cnt - base_v); end
        checks++;
        if (done_cnt - base_d !== 2) begin failures++; $display("[TB] FAIL two_pass_done_count: got %0d expected 2", done_cnt - base_d); end
        checks++;
        if (done_at - base_v !== 64) begin failures++; $display("[TB] FAIL two_pass_done_position: got %0d expected 64", done_at - base_v); end
        for (int i = 0; i < 32; i++) begin
            read_weight(5'(i), rd);
            checks++;
            if (rd !== 32'h3F400000) begin failures++; $display("[TB] FAIL two_pass_w%0d: got %h expected 3F400000", i, rd); end
        end
    endtask

    initial begin
        test_reset();
        test_single_update();
        test_back_to_back();
        test_clip();
        test_load_while_busy();
        test_mid_reset();
        test_two_passes();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
